// File: rtl/calc_pkg.sv
// Shared calculator definitions: FSM state codes seen by the display path
// and the formatter's own conversion FSM states.
package calc_pkg;

  localparam logic [3:0] ST_RES    = 4'd0;
  localparam logic [3:0] ST_A0     = 4'd4;
  localparam logic [3:0] ST_A_LAST = 4'd7;
  localparam logic [3:0] ST_B0     = 4'd8;
  localparam logic [3:0] ST_B_LAST = 4'd10;
  localparam logic [3:0] ST_SHOW   = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } fmt_state_t;

endpackage

// File: rtl/disp_formatter_if.sv
// Calculator-to-display bundle: operand/result sources in, formatted digits out.
interface disp_formatter_if #(
  parameter int W      = 16,
  parameter int DIGITS = 8
);
  logic [3:0]          state;
  logic [W-1:0]        a;
  logic [W-1:0]        b;
  logic [W:0]          res;
  logic                dec_mode;
  logic [4*DIGITS-1:0] num;
  logic [DIGITS-1:0]   dig_en;
  logic                blink_on;
  logic                busy;

  modport master (
    output state, a, b, res, dec_mode,
    input  num, dig_en, blink_on, busy
  );

  modport slave (
    input  state, a, b, res, dec_mode,
    output num, dig_en, blink_on, busy
  );
endinterface

// File: rtl/disp_formatter_bcd_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) adjusted = digit + 4'd3;
  end
endmodule

// File: rtl/disp_formatter.sv
// Display formatter: picks the value for the current calculator state and
// shows it as hex or as sequentially converted BCD, with blanking and blink.
module disp_formatter
  import calc_pkg::*;
#(
  parameter int W         = 16,
  parameter int DIGITS    = 8,
  parameter int BLINK_CYC = 50_000_000
) (
  input logic             clk,
  input logic             reset,
  disp_formatter_if.slave bus
);
  localparam int NW   = 4 * DIGITS;
  localparam int CNTW = $clog2(W + 1);
  localparam int BCW  = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  fmt_state_t      fsm_q, fsm_d;
  logic [W:0]      sel_d, sel_q, last_val;
  logic            mode_q, last_mode;
  logic [NW-1:0]   num_q, bcd_q, bcd_adj;
  logic [W:0]      bin_q;
  logic [CNTW-1:0] cnt_q;
  logic            busy_q;
  logic [BCW-1:0]  blink_cnt;
  logic            blink_q;
  logic            start, do_hex, do_load, do_step, do_done, in_entry;

  always_comb begin
    sel_d = '0;
    if (bus.state == ST_RES || bus.state == ST_SHOW)
      sel_d = bus.res;
    else if (bus.state >= ST_A0 && bus.state <= ST_A_LAST)
      sel_d = {1'b0, bus.a};
    else if (bus.state >= ST_B0 && bus.state <= ST_B_LAST)
      sel_d = {1'b0, bus.b};
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.digit(bcd_q[4*g +: 4]), .adjusted(bcd_adj[4*g +: 4]));
  end

  // A new value or mode restarts from IDLE semantics even mid-conversion.
  assign start = (sel_q != last_val) || (mode_q != last_mode);

  always_comb begin
    fsm_d   = fsm_q;
    do_hex  = 1'b0;
    do_load = 1'b0;
    do_step = 1'b0;
    do_done = 1'b0;
    if (start) begin
      if (mode_q) begin
        do_load = 1'b1;
        fsm_d   = CONV;
      end else begin
        do_hex = 1'b1;
        fsm_d  = IDLE;
      end
    end else if (fsm_q == CONV) begin
      do_step = 1'b1;
      if (cnt_q == CNTW'(W)) begin
        do_done = 1'b1;
        fsm_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q     <= '0;
      mode_q    <= 1'b0;
      last_val  <= '0;
      last_mode <= 1'b0;
      num_q     <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      mode_q <= bus.dec_mode;
      if (do_hex) begin
        num_q     <= NW'(sel_q);
        last_val  <= sel_q;
        last_mode <= mode_q;
        busy_q    <= 1'b0;
      end
      if (do_load) begin
        bcd_q     <= '0;
        bin_q     <= sel_q;
        cnt_q     <= '0;
        last_val  <= sel_q;
        last_mode <= mode_q;
        busy_q    <= 1'b1;
      end
      if (do_step) begin
        // Top BCD bit rotates into bin; it cannot reach the digits within W+1 shifts.
        {bcd_q, bin_q} <= {bcd_adj[NW-2:0], bin_q, bcd_adj[NW-1]};
        cnt_q          <= cnt_q + 1'b1;
      end
      if (do_done) begin
        num_q  <= {bcd_adj[NW-2:0], bin_q[W]};
        busy_q <= 1'b0;
      end
    end
  end

  assign in_entry = (bus.state >= ST_A0) && (bus.state <= ST_B_LAST);

  // Outside entry states the counter is held clear, so entry starts a fresh "on" phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (!in_entry) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt == BCW'(BLINK_CYC - 1)) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    logic        seen;
    int unsigned idx;
    seen       = 1'b0;
    idx        = 0;
    bus.dig_en = '0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      idx             = DIGITS - 1 - j;
      seen            = seen | (num_q[4*idx +: 4] != 4'd0);
      bus.dig_en[idx] = seen;
    end
    bus.dig_en[0] = 1'b1;
  end

  assign bus.num      = num_q;
  assign bus.busy     = busy_q;
  assign bus.blink_on = blink_q;

endmodule

// File: tb/tb_disp_formatter.sv
// Directed bench for disp_formatter: vector table plus abort, reset and blink sequences.
module tb_disp_formatter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  disp_formatter_if #(.W(16), .DIGITS(8)) bus ();

  disp_formatter #(.W(16), .DIGITS(8), .BLINK_CYC(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]  state;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] res;
    logic        dec;
    logic [31:0] num;
    logic [7:0]  en;
    int unsigned lat;
  } vec_t;

  vec_t vecs[12];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] st, input logic [15:0] av, input logic [15:0] bv,
                       input logic [16:0] rv, input logic dm);
    bus.state    = st;
    bus.a        = av;
    bus.b        = bv;
    bus.res      = rv;
    bus.dec_mode = dm;
  endtask

  initial begin
    logic [31:0] prev;
    logic [11:0] blink_exp;
    int          busy_cnt;
    int          bad_seen;

    vecs[0]  = '{4'd4,  16'h1234, 16'h0,    17'h0,     1'b0, 32'h00001234, 8'h0F, 2};
    vecs[1]  = '{4'd8,  16'h0,    16'hBEEF, 17'h0,     1'b0, 32'h0000BEEF, 8'h0F, 2};
    vecs[2]  = '{4'd0,  16'h0,    16'h0,    17'h1ABCD, 1'b0, 32'h0001ABCD, 8'h1F, 2};
    vecs[3]  = '{4'd2,  16'h5555, 16'h6666, 17'h7777,  1'b0, 32'h00000000, 8'h01, 2};
    vecs[4]  = '{4'd0,  16'h0,    16'h0,    17'h1FFFF, 1'b1, 32'h00131071, 8'h3F, 19};
    vecs[5]  = '{4'd11, 16'h0,    16'h0,    17'd99,    1'b1, 32'h00000099, 8'h03, 19};
    vecs[6]  = '{4'd11, 16'h0,    16'h0,    17'd0,     1'b1, 32'h00000000, 8'h01, 19};
    vecs[7]  = '{4'd6,  16'd1000, 16'h0,    17'h0,     1'b1, 32'h00001000, 8'h0F, 19};
    vecs[8]  = '{4'd9,  16'h0,    16'd65535, 17'h0,    1'b1, 32'h00065535, 8'h1F, 19};
    vecs[9]  = '{4'd0,  16'h0,    16'h0,    17'h10000, 1'b1, 32'h00065536, 8'h1F, 19};
    vecs[10] = '{4'd7,  16'h00FF, 16'h0,    17'h0,     1'b0, 32'h000000FF, 8'h03, 2};
    vecs[11] = '{4'd7,  16'h00FF, 16'h0,    17'h0,     1'b1, 32'h00000255, 8'h07, 19};

    drive(4'd1, 16'h0, 16'h0, 17'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_num", bus.num, 32'h0);
    check("reset_en", {24'h0, bus.dig_en}, 32'h01);
    check("reset_busy", {31'h0, bus.busy}, 32'h0);
    check("reset_blink", {31'h0, bus.blink_on}, 32'h1);
    reset = 1'b0;

    prev = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].state, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dec);
      repeat (vecs[i].lat - 1) @(negedge clk);
      check($sformatf("v%0d_hold", i), bus.num, prev);
      @(negedge clk);
      check($sformatf("v%0d_num", i), bus.num, vecs[i].num);
      check($sformatf("v%0d_en", i), {24'h0, bus.dig_en}, {24'h0, vecs[i].en});
      check($sformatf("v%0d_busy", i), {31'h0, bus.busy}, 32'h0);
      prev = vecs[i].num;
    end

    // Decimal 0x1FFFF: busy for 17 cycles, result exactly at edge 19.
    drive(4'd1, 16'h0, 16'h0, 17'h0, 1'b0);
    repeat (3) @(negedge clk);
    drive(4'd0, 16'h0, 16'h0, 17'h1FFFF, 1'b1);
    busy_cnt = 0;
    bad_seen = 0;
    for (int e = 1; e <= 19; e++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (e < 19 && bus.num !== 32'h0) bad_seen++;
    end
    check("max_busy_cycles", busy_cnt, 17);
    check("max_early_num", bad_seen, 0);
    check("max_num", bus.num, 32'h00131071);
    check("max_en", {24'h0, bus.dig_en}, 32'h3F);

    // Abort: a=1000 replaced by 42 after CONV cycle 5; reload at edge 9, result at 26.
    drive(4'd1, 16'h0, 16'h0, 17'h0, 1'b0);
    repeat (3) @(negedge clk);
    drive(4'd4, 16'd1000, 16'h0, 17'h0, 1'b1);
    bad_seen = 0;
    for (int e = 1; e <= 26; e++) begin
      @(negedge clk);
      if (e == 7) bus.a = 16'd42;
      if (e < 26 && bus.num !== 32'h0) bad_seen++;
      if (e == 25) check("abort_busy_before", {31'h0, bus.busy}, 32'h1);
    end
    check("abort_no_partial", bad_seen, 0);
    check("abort_num", bus.num, 32'h00000042);
    check("abort_busy_after", {31'h0, bus.busy}, 32'h0);

    // Reset asserted in the middle of a conversion.
    @(negedge clk);
    drive(4'd4, 16'h1234, 16'h0, 17'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_reset_num", bus.num, 32'h00001234);
    drive(4'd0, 16'h0, 16'h0, 17'h1FFFF, 1'b1);
    repeat (10) @(negedge clk);
    check("pre_reset_busy", {31'h0, bus.busy}, 32'h1);
    check("pre_reset_hold", bus.num, 32'h00001234);
    reset = 1'b1;
    drive(4'd1, 16'h0, 16'h0, 17'h0, 1'b0);
    #1;
    check("rst_mid_num", bus.num, 32'h0);
    check("rst_mid_en", {24'h0, bus.dig_en}, 32'h01);
    check("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    busy_cnt = 0;
    bad_seen = 0;
    for (int e = 0; e < 25; e++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.num !== 32'h0) bad_seen++;
    end
    check("post_rst_busy", busy_cnt, 0);
    check("post_rst_num", bad_seen, 0);

    // Blink: entering state 5 gives 1111 0000 1111, leaving restores 1 next edge.
    blink_exp = 12'b1111_0000_1111;
    @(negedge clk);
    bus.state = 4'd5;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("blink_%0d", k), {31'h0, bus.blink_on}, {31'h0, blink_exp[11-k]});
    end
    @(negedge clk);
    check("blink_12", {31'h0, bus.blink_on}, 32'h0);
    bus.state = 4'd11;
    @(posedge clk);
    #1;
    check("blink_leave", {31'h0, bus.blink_on}, 32'h1);
    repeat (5) @(negedge clk);
    check("blink_steady", {31'h0, bus.blink_on}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_formatter.md
DISP_FORMATTER -- requirements
Module: disp_formatter

Interface
REQ-001 Parameter: W, 16, operand width of a and b; res is W+1 bits wide.
REQ-002 Parameter: DIGITS, 8, display digit count; num is 4*DIGITS bits wide; DIGITS SHALL be at least the decimal digit count of 2^(W+1)-1.
REQ-003 Parameter: BLINK_CYC, 50_000_000, clock cycles per blink half-period.
REQ-004 Port: clk, input, 1, system clock; all state SHALL update on its rising edge.
REQ-005 Port: reset, input, 1, asynchronous, active-high reset.
REQ-006 Port: state, input, 4, calculator FSM state code.
REQ-007 Port: a, input, W, first operand.
REQ-008 Port: b, input, W, second operand.
REQ-009 Port: res, input, W+1, result; bit W is the carry.
REQ-010 Port: dec_mode, input, 1; 1 selects decimal (BCD) display and 0 selects hex display.
REQ-011 Port: num, output, 4*DIGITS, digit nibbles; digit 0 is in the LSBs.
REQ-012 Port: dig_en, output, DIGITS, per-digit enable with leading zeros blanked.
REQ-013 Port: blink_on, output, 1, display gate used for entry blinking.
REQ-014 Port: busy, output, 1, high while a decimal conversion runs.

Function
REQ-015 The source mux SHALL select res for state 0 and 11; a zero-extended for states 4-7; b zero-extended for states 8-10; zero for states 1-3 and 12-15. The selected value SHALL be W+1 bits wide and SHALL be registered as sel_q at edge 1.
REQ-016 The FSM SHALL have two states, IDLE and CONV. In IDLE, it SHALL start a new conversion when sel_q differs from the last displayed value, or when dec_mode differs from the last displayed mode.
REQ-017 In hex mode, from IDLE at edge 2: num SHALL be sel_q zero-extended, and the last value and mode SHALL be recorded. The FSM SHALL stay in IDLE, giving a latency of 2 edges from an input change.
REQ-018 In decimal mode, from IDLE at edge 2: the double-dabble shift register SHALL be loaded, busy SHALL be set to 1, and the FSM SHALL move to CONV.
REQ-019 In CONV, each cycle SHALL perform one add-3 (digit >= 5) followed by a shift, for W+1 cycles in total.
REQ-020 On the final shift, num SHALL take the BCD result, busy SHALL drop to 0, and the FSM SHALL return to IDLE. The latency SHALL be W+3 edges, which is 19 for W=16.
REQ-021 Until REQ-017 or REQ-020 updates it, num SHALL hold its previous value and SHALL never show partial results.
REQ-022 If sel_q or dec_mode changes during CONV, the conversion SHALL abort and reload from the new value on the next edge. The latency SHALL then count from the reload.
REQ-023 dig_en bit i SHALL be 1 if digit i or any higher digit is nonzero. Bit 0 SHALL always be 1. dig_en SHALL update on the same edge as num.
REQ-024 blink_on SHALL be 1 whenever state is not in the range 4-10.
REQ-025 While state is in 4-10, blink_on SHALL toggle every BLINK_CYC cycles.
REQ-026 The blink counter SHALL clear, and blink_on SHALL be 1, on the first cycle that state enters 4-10 from outside that range.
REQ-027 The carry res[W] SHALL be shown in both modes, as hex digit W/4 or as part of the decimal value.

Reset
REQ-028 When reset is asserted: num SHALL be 0, dig_en SHALL be 1, busy SHALL be 0, blink_on SHALL be 1, the FSM SHALL be in IDLE, the last value SHALL be 0, the last mode SHALL be 0, sel_q SHALL be 0, and the blink counter SHALL be 0.
REQ-029 Reset asserted mid-CONV SHALL abort the conversion immediately. No result SHALL be written.
REQ-030 After reset deasserts, a nonzero input SHALL trigger a fresh conversion per REQ-016.

Structure
REQ-031 The shared package calc_pkg SHALL hold the state-code constants (ST_RES=0, ST_A0=4, ST_A_LAST=7, ST_B0=8, ST_B_LAST=10, ST_SHOW=11) and the FSM enum type fmt_state_t (IDLE, CONV).
REQ-032 The add-3 digit correction SHALL be one sub-module, bcd_add3, with a 4-bit input and a 4-bit output. It SHALL be instantiated DIGITS times by a generate loop.
REQ-033 The source mux, FSM, blanking logic and blink counter SHALL reside in disp_formatter.

Verification (W=16, DIGITS=8, BLINK_CYC=4 in bench)
REQ-034 Hex mode, state=4, a=16'h1234, reset released -> 2 edges later num=32'h00001234 and dig_en=8'b00001111; busy stays 0.
REQ-035 Decimal mode, state=0, res=17'h1FFFF -> busy high for 17 cycles; at edge 19 num=32'h00131071 and dig_en=8'b00111111; num unchanged before edge 19.
REQ-036 Decimal mode, state=11, res=0 after a prior value of 99 -> num=32'h00000000 and dig_en=8'b00000001.
REQ-037 Decimal conversion of a=1000 (state=4) with a changed to 42 at CONV cycle 5 -> num never shows 1000 or any partial result; num=32'h00000042 at 17 edges after the reload.
REQ-038 Reset pulsed at CONV cycle 8 -> num=0, dig_en=1 and busy=0 immediately; no update occurs after release with an unchanged zero input.
REQ-039 State moved 0 -> 5 -> blink_on sequence is 1111 0000 1111; state moved 5 -> 11 -> blink_on is 1 from the next edge.
